// File: rtl/avm_sram16_ctrl.sv
// Avalon-MM 32-bit slave to 16-bit asynchronous SRAM bridge: two timed half-accesses per word.
// Optional macro AVM_SRAM16_SKIP_EN skips halves whose byte enables are both clear.
`timescale 1ns/1ps
module avm_sram16_ctrl #(
  parameter int unsigned AADDR_WIDTH = 20,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   avm_clk,
  input  logic                   avm_rst_n,
  input  logic                   avm_read,
  input  logic                   avm_write,
  input  logic [AADDR_WIDTH-1:0] avm_address,
  input  logic [3:0]             avm_byteenable,
  input  logic [2:0]             avm_burstcount,
  input  logic [31:0]            avm_writedata,
  output logic                   avm_waitrequest,
  output logic                   avm_readdatavalid,
  output logic [31:0]            avm_readdata,
  output logic [AADDR_WIDTH:0]   sram_addr,
  output logic [15:0]            sram_dq_o,
  input  logic [15:0]            sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_lb_n,
  output logic                   sram_ub_n
);

`ifdef AVM_SRAM16_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  localparam logic [3:0] LastPc = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             pc_q, pc_d;
  logic [AADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]             be_q, be_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic                   null_q, null_d;
  logic [15:0]            lo_q, lo_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rdv_q, rdv_d;

  logic phase_end;
  logic hi_skip;
  logic unused_burst;

  assign unused_burst = ^avm_burstcount;
  // A null transfer (all enables clear, skip build) spends a single cycle in StLo.
  assign phase_end = (pc_q == LastPc) || null_q;
  assign hi_skip   = SkipEn && (be_q[3:2] == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    null_d  = null_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (avm_read || avm_write) begin
          addr_d  = avm_address;
          be_d    = avm_byteenable;
          wdata_d = avm_writedata;
          wr_d    = avm_write;
          null_d  = SkipEn && (avm_byteenable == 4'b0000);
          pc_d    = '0;
          if (SkipEn && (avm_byteenable[1:0] == 2'b00) && (avm_byteenable[3:2] != 2'b00)) begin
            state_d = StHi;
          end else begin
            state_d = StLo;
          end
        end
      end
      StLo: begin
        if (phase_end) begin
          pc_d = '0;
          lo_d = null_q ? 16'h0000 : sram_dq_i;
          if (null_q || hi_skip) begin
            state_d = StIdle;
            if (!wr_q) begin
              rdv_d   = 1'b1;
              rdata_d = {16'h0000, (null_q ? 16'h0000 : sram_dq_i)};
            end
          end else begin
            state_d = StHi;
          end
        end else begin
          pc_d = pc_q + 4'd1;
        end
      end
      StHi: begin
        if (phase_end) begin
          pc_d    = '0;
          state_d = StIdle;
          if (!wr_q) begin
            rdv_d   = 1'b1;
            rdata_d = {sram_dq_i, ((SkipEn && (be_q[1:0] == 2'b00)) ? 16'h0000 : lo_q)};
          end
        end else begin
          pc_d = pc_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_dq_o  = '0;
    sram_addr  = '0;
    if ((state_q == StLo && !null_q) || state_q == StHi) begin
      sram_ce_n  = 1'b0;
      sram_oe_n  = wr_q;
      // Write strobe stays high in cycle 0 so address settles before we_n falls.
      sram_we_n  = !(wr_q && (pc_q != 4'd0));
      sram_dq_oe = wr_q;
      if (state_q == StLo) begin
        sram_addr = {addr_q, 1'b0};
        sram_lb_n = ~be_q[0];
        sram_ub_n = ~be_q[1];
        sram_dq_o = wr_q ? wdata_q[15:0] : 16'h0000;
      end else begin
        sram_addr = {addr_q, 1'b1};
        sram_lb_n = ~be_q[2];
        sram_ub_n = ~be_q[3];
        sram_dq_o = wr_q ? wdata_q[31:16] : 16'h0000;
      end
    end
  end

  assign avm_waitrequest   = (state_q != StIdle);
  assign avm_readdatavalid = rdv_q;
  assign avm_readdata      = rdata_q;

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      null_q  <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      null_q  <= null_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
    end
  end

endmodule
